dp_imm_gen_pipe: RTL and testbench
==================================

# dp_imm_gen_pipe

Pipelined, parametrised immediate generator for the datapath's decode stage. It decodes every RV base immediate format (I, S, B, U, J) at XLEN 32 or 64, sign-extends to XLEN, and computes the PC-relative target `pc + imm`. It flags unsupported opcodes and counts them. A valid/ready handshake with a 2-entry skid buffer lets it sit between fetch and execute, with full throughput under backpressure.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  instr/in_pc valid
- in_ready  output  1  block can accept this cycle
- instr  input  32  instruction word
- in_pc  input  XLEN  PC of instr
- out_valid  output  1  output entry valid
- out_ready  input  1  consumer accepts this cycle
- out_imm  output  XLEN  sign-extended immediate
- out_fmt  output  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J; 6–7 unused
- out_target  output  XLEN  (in_pc + out_imm) mod 2^XLEN
- out_illegal  output  1  opcode not supported
- illegal_cnt  output  16  saturating count of accepted illegal instructions

## Operation
- Decode, combinational on instr[6:0]:
  - I: 0010011, 0000011, 1100111; also 0011011 when XLEN=64. imm = sext(instr[31:20]).
  - S: 0100011. imm = sext({instr[31:25], instr[11:7]}).
  - B: 1100011. imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U: 0110111, 0010111. imm = sext({instr[31:12], 12'b0}) to XLEN.
  - J: 1101111. imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - NONE: 0110011 and 1110011; also 0111011 when XLEN=64. imm = 0, not illegal.
  - Any other opcode: fmt NONE, imm 0, illegal = 1. This includes 0011011/0111011 when XLEN=32.
- out_target is always pc + imm with wrap-around. It is meaningful only for B, J and AUIPC; consumers ignore it otherwise.
- Decoded results are captured into the pipeline on acceptance; nothing is decoded at the output.
- Buffering uses a main register (drives outputs) and a skid register.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- Accept when main is empty or draining, and skid is empty: the entry goes to main.
- Accept when main is full and not draining: the entry goes to skid.
- Drain with skid full: skid moves to main and skid becomes empty. No accept is possible that cycle, because in_ready = 0.
- in_ready = ~skid_valid, registered. There is no combinational path from out_ready to in_ready.
- Order is strictly preserved. No entry is dropped or duplicated.
- Outputs stay stable while out_valid & ~out_ready.
- illegal_cnt increments by 1 on every accept with illegal = 1 and saturates at 0xFFFF. It is cleared only by reset.

## Timing
- Reset (rst_n low, asynchronous): out_valid=0, in_ready=1, out_imm=0, out_fmt=0, out_target=0, out_illegal=0, illegal_cnt=0, skid empty.
- Latency: accepted in cycle N gives out_valid=1 from cycle N+1.
- Throughput: 1 entry/cycle while out_ready=1.
- Backpressure: with out_ready=0, at most 2 entries are accepted. in_ready drops the cycle after the second accept.
- in_ready returns to 1 the cycle after skid empties.
- Simultaneous accept and drain with skid empty: main is loaded with the new entry; out_valid stays 1.
- Reset mid-operation: both entries are discarded immediately and the counter is cleared. The first accept after rst_n rises behaves as from reset.

## Test plan
- ADDI x1,x0,-1: instr 0xFFF00093, pc 0x0 -> next cycle out_imm 0xFFFFFFFF, fmt 1, illegal 0.
- BEQ -4: instr 0xFE000EE3, pc 0x100 -> out_imm 0xFFFFFFFC, fmt 3, out_target 0x000000FC.
- LUI 0x12345 (0x123452B7) -> imm 0x12345000, fmt 4. JAL ra,+2048 (0x001000EF), pc 0x1000 -> imm 0x800, fmt 5, target 0x1800.
- Backpressure: out_ready=0, drive 3 back-to-back instructions -> 2 accepted, in_ready=0 on the third. Raise out_ready -> 3 outputs in order on consecutive cycles, data stable while stalled.
- Illegal handling: instr 0x0000007F -> illegal 1, imm 0, illegal_cnt 1. 0x0010009B (ADDIW) -> XLEN=64: fmt 1, imm 1; XLEN=32: illegal, cnt increments.
- Reset mid-stream: two entries buffered, pulse rst_n low -> out_valid 0, in_ready 1, illegal_cnt 0 immediately. Check illegal_cnt saturation at 0xFFFF after 65536+ illegal accepts.

Source files
------------

// File: rtl/dp_imm_gen_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : dp_imm_gen_pipe_if
//  Description : Handshake/data bundle for the pipelined immediate generator.
//                Upstream side : in_valid, in_ready, instr, in_pc
//                Downstream    : out_valid, out_ready, out_imm, out_fmt,
//                                out_target, out_illegal
//                Status        : illegal_cnt
//                modport slave  - seen by the generator
//                modport master - seen by whoever drives/consumes it
//  Revision    : 1.0 - initial release
// ============================================================================
interface dp_imm_gen_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic [XLEN-1:0] out_target;
  logic            out_illegal;
  logic [15:0]     illegal_cnt;

  modport slave (
    input  in_valid, instr, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_target, out_illegal,
           illegal_cnt
  );

  modport master (
    output in_valid, instr, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_target, out_illegal,
           illegal_cnt
  );
endinterface
`default_nettype wire

// File: rtl/dp_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : dp_imm_gen_pipe
//  Description : Decode-stage immediate generator. Decodes RV I/S/B/U/J
//                immediates (XLEN 32 or 64), sign-extends to XLEN, forms
//                pc + imm, flags unsupported opcodes and counts them.
//                Results sit in a main register (drives outputs) backed by a
//                skid register so in_ready can be a pure flop.
//  Ports       : clk   - clock, rising edge
//                rst_n - asynchronous active-low reset
//                bus   - dp_imm_gen_pipe_if.slave (handshakes, data, count)
//  Revision    : 1.0 - initial release
// ============================================================================
module dp_imm_gen_pipe #(
  parameter int XLEN = 32
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  dp_imm_gen_pipe_if.slave   bus
);

  localparam bit IS_RV64 = (XLEN == 64);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  // --------------------------------------------------------------------------
  // Decode (combinational, on the incoming instruction)
  // --------------------------------------------------------------------------
  logic [31:0]        instr;
  logic [6:0]         opcode;
  logic signed [31:0] imm32;    // every format fits in 32 bits before extension
  logic [2:0]         dec_fmt;
  logic               dec_illegal;
  entry_t             dec_entry;

  assign instr  = bus.instr;
  assign opcode = instr[6:0];

  always_comb begin
    dec_fmt     = FMT_NONE;
    dec_illegal = 1'b0;
    imm32       = '0;
    case (opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        dec_fmt = FMT_I;
        imm32   = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_OP_IMM_32: begin
        if (IS_RV64) begin
          dec_fmt = FMT_I;
          imm32   = {{20{instr[31]}}, instr[31:20]};
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OPC_STORE: begin
        dec_fmt = FMT_S;
        imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        dec_fmt = FMT_B;
        imm32   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                   instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_fmt = FMT_U;
        imm32   = {instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        dec_fmt = FMT_J;
        imm32   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                   instr[30:21], 1'b0};
      end
      OPC_OP, OPC_SYSTEM: begin
        dec_fmt = FMT_NONE;
      end
      OPC_OP_32: begin
        // Legal register-register op only on RV64; otherwise unsupported.
        dec_illegal = !IS_RV64;
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  always_comb begin
    dec_entry         = '0;
    // Size cast of a signed operand sign-extends to XLEN.
    dec_entry.imm     = XLEN'(imm32);
    dec_entry.target  = bus.in_pc + XLEN'(imm32);
    dec_entry.fmt     = dec_fmt;
    dec_entry.illegal = dec_illegal;
  end

  // --------------------------------------------------------------------------
  // Main + skid buffering
  // --------------------------------------------------------------------------
  logic        main_valid_q, main_valid_d;
  entry_t      main_q, main_d;
  logic        skid_valid_q, skid_valid_d;
  entry_t      skid_q, skid_d;
  logic        in_ready_q, in_ready_d;
  logic [15:0] illegal_cnt_q, illegal_cnt_d;
  logic        accept;
  logic        drain;

  assign accept = bus.in_valid & in_ready_q;
  assign drain  = main_valid_q & bus.out_ready;

  always_comb begin
    main_valid_d  = main_valid_q;
    main_d        = main_q;
    skid_valid_d  = skid_valid_q;
    skid_d        = skid_q;
    illegal_cnt_d = illegal_cnt_q;

    if (skid_valid_q) begin
      // in_ready is low whenever skid holds data, so no accept can occur here.
      if (drain) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q || drain) begin
        main_valid_d = 1'b1;
        main_d       = dec_entry;
      end else begin
        skid_valid_d = 1'b1;
        skid_d       = dec_entry;
      end
    end else if (drain) begin
      // Data fields are left as-is; only the valid flag drops.
      main_valid_d = 1'b0;
    end

    if (accept && dec_illegal && (illegal_cnt_q != CNT_MAX)) begin
      illegal_cnt_d = illegal_cnt_q + 16'd1;
    end

    // Registered ready: reflects next-cycle skid occupancy, never out_ready.
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q  <= 1'b0;
      main_q        <= '0;
      skid_valid_q  <= 1'b0;
      skid_q        <= '0;
      in_ready_q    <= 1'b1;
      illegal_cnt_q <= '0;
    end else begin
      main_valid_q  <= main_valid_d;
      main_q        <= main_d;
      skid_valid_q  <= skid_valid_d;
      skid_q        <= skid_d;
      in_ready_q    <= in_ready_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = main_valid_q;
  assign bus.out_imm     = main_q.imm;
  assign bus.out_fmt     = main_q.fmt;
  assign bus.out_target  = main_q.target;
  assign bus.out_illegal = main_q.illegal;
  assign bus.illegal_cnt = illegal_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dp_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dp_imm_gen_pipe
//  Description : Directed self-checking bench for dp_imm_gen_pipe (XLEN=32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dp_imm_gen_pipe;

  localparam int XLEN = 32;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  dp_imm_gen_pipe_if #(.XLEN(XLEN)) bus ();

  dp_imm_gen_pipe #(.XLEN(XLEN)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] i,
                       input logic [31:0] pc);
    bus.in_valid = v;
    bus.instr    = i;
    bus.in_pc    = pc;
  endtask

  task automatic check_out(input string tag, input logic [31:0] imm,
                           input logic [2:0] fmt, input logic [31:0] tgt,
                           input logic ill);
    check({tag, ".valid"},   64'(bus.out_valid),   64'd1);
    check({tag, ".imm"},     64'(bus.out_imm),     64'(imm));
    check({tag, ".fmt"},     64'(bus.out_fmt),     64'(fmt));
    check({tag, ".target"},  64'(bus.out_target),  64'(tgt));
    check({tag, ".illegal"}, 64'(bus.out_illegal), 64'(ill));
  endtask

  initial begin
    n_checks      = 0;
    n_fails       = 0;
    rst_n         = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    tick();

    // Reset state
    check("rst.out_valid",   64'(bus.out_valid),   64'd0);
    check("rst.in_ready",    64'(bus.in_ready),    64'd1);
    check("rst.out_imm",     64'(bus.out_imm),     64'd0);
    check("rst.out_fmt",     64'(bus.out_fmt),     64'd0);
    check("rst.out_target",  64'(bus.out_target),  64'd0);
    check("rst.out_illegal", 64'(bus.out_illegal), 64'd0);
    check("rst.illegal_cnt", 64'(bus.illegal_cnt), 64'd0);
    rst_n = 1'b1;
    tick();

    // Streaming decode, out_ready high: one result per cycle
    bus.out_ready = 1'b1;
    drive(1'b1, 32'hFFF00093, 32'h0000_0000);     // ADDI x1,x0,-1
    tick();
    check_out("addi", 32'hFFFFFFFF, 3'd1, 32'hFFFFFFFF, 1'b0);
    drive(1'b1, 32'hFE000EE3, 32'h0000_0100);     // BEQ -4
    tick();
    check_out("beq", 32'hFFFFFFFC, 3'd3, 32'h000000FC, 1'b0);
    drive(1'b1, 32'h123452B7, 32'h0000_0000);     // LUI 0x12345
    tick();
    check_out("lui", 32'h12345000, 3'd4, 32'h12345000, 1'b0);
    drive(1'b1, 32'h001000EF, 32'h0000_1000);     // JAL ra,+2048
    tick();
    check_out("jal", 32'h00000800, 3'd5, 32'h00001800, 1'b0);
    drive(1'b1, 32'h00001097, 32'h0000_2000);     // AUIPC x1,1
    tick();
    check_out("auipc", 32'h00001000, 3'd4, 32'h00003000, 1'b0);
    drive(1'b1, 32'hFE20AC23, 32'h0000_0010);     // SW x2,-8(x1)
    tick();
    check_out("sw", 32'hFFFFFFF8, 3'd2, 32'h00000008, 1'b0);
    drive(1'b1, 32'h002081B3, 32'h0000_0020);     // ADD (no immediate)
    tick();
    check_out("add", 32'h0, 3'd0, 32'h00000020, 1'b0);
    check("add.in_ready", 64'(bus.in_ready), 64'd1);

    // Illegal opcodes and RV64-only opcode on RV32
    drive(1'b1, 32'h0000007F, 32'h0000_0040);
    tick();
    check_out("ill7f", 32'h0, 3'd0, 32'h00000040, 1'b1);
    check("ill7f.cnt", 64'(bus.illegal_cnt), 64'd1);
    drive(1'b1, 32'h0010009B, 32'h0000_0044);     // ADDIW
    tick();
    check_out("addiw", 32'h0, 3'd0, 32'h00000044, 1'b1);
    check("addiw.cnt", 64'(bus.illegal_cnt), 64'd2);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check("drain.out_valid", 64'(bus.out_valid), 64'd0);

    // Backpressure: two accepts, third held off by in_ready
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 32'h0);             // ADDI imm 1
    tick();
    check_out("bp.a", 32'd1, 3'd1, 32'd1, 1'b0);
    check("bp.a.in_ready", 64'(bus.in_ready), 64'd1);
    drive(1'b1, 32'h00200093, 32'h0);             // ADDI imm 2
    tick();
    check("bp.b.in_ready", 64'(bus.in_ready), 64'd0);
    check_out("bp.b.stall", 32'd1, 3'd1, 32'd1, 1'b0);
    drive(1'b1, 32'h00300093, 32'h0);             // ADDI imm 3, held
    tick();
    check("bp.c.in_ready", 64'(bus.in_ready), 64'd0);
    check_out("bp.c.stall", 32'd1, 3'd1, 32'd1, 1'b0);
    tick();
    check_out("bp.c.stall2", 32'd1, 3'd1, 32'd1, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    check_out("bp.out2", 32'd2, 3'd1, 32'd2, 1'b0);
    check("bp.out2.in_ready", 64'(bus.in_ready), 64'd1);
    tick();                                       // C accepted as B drains
    check_out("bp.out3", 32'd3, 3'd1, 32'd3, 1'b0);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check("bp.empty", 64'(bus.out_valid), 64'd0);

    // Reset mid-stream with two entries buffered
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h0000007F, 32'h0);
    tick();
    drive(1'b1, 32'h00100093, 32'h0);
    tick();
    check("mid.in_ready_pre", 64'(bus.in_ready), 64'd0);
    drive(1'b0, 32'h0, 32'h0);
    #1 rst_n = 1'b0;
    #1;
    check("mid.out_valid",   64'(bus.out_valid),   64'd0);
    check("mid.in_ready",    64'(bus.in_ready),    64'd1);
    check("mid.illegal_cnt", 64'(bus.illegal_cnt), 64'd0);
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 32'hFFF00093, 32'h0);
    tick();
    check_out("post_rst", 32'hFFFFFFFF, 3'd1, 32'hFFFFFFFF, 1'b0);

    // Counter saturation
    drive(1'b1, 32'h0000007F, 32'h0);
    for (int i = 0; i < 65534; i++) tick();
    check("sat.fffe", 64'(bus.illegal_cnt), 64'hFFFE);
    tick();
    check("sat.ffff", 64'(bus.illegal_cnt), 64'hFFFF);
    tick();
    tick();
    check("sat.hold", 64'(bus.illegal_cnt), 64'hFFFF);
    drive(1'b0, 32'h0, 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
